bf16_to_int: RTL and testbench
==============================

BF16_TO_INT -- requirements
Module: bf16_to_int

Interface
REQ-001 SHALL have parameter IN_W, default `INPUTOUTBIT (16), meaning the BF16 input width.
REQ-002 SHALL have parameter OUT_W, default 2*`INPUTOUTBIT (32), meaning the signed integer result width.
REQ-003 SHALL have port clk, input, 1, the clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1, the reset: asynchronous, active-high.
REQ-005 SHALL have port start, input, 1, a one-cycle pulse qualifying a; any cycle, back-to-back allowed.
REQ-006 SHALL have port a, input, IN_W, the BF16 operand {sign, exp[7:0], mant[6:0]}.
REQ-007 SHALL have port result, output reg, OUT_W, the signed two's-complement integer.
REQ-008 SHALL have port error, output reg, 1, the exception flag for the result delivered with the same done.
REQ-009 SHALL have port done, output reg, 1, a one-cycle pulse marking result/error valid.

Function
REQ-010 SHALL run a 3-stage pipeline: unpack/classify, align, sign/saturate; done asserts exactly 3 cycles after the cycle start was sampled high.
REQ-011 SHALL accept one operand per cycle; N consecutive start pulses SHALL give N consecutive done pulses in order.
REQ-012 SHALL hold result and error between done pulses; done SHALL be low in every other cycle.
REQ-013 Stage 1 SHALL classify on exp: 0 gives zero (subnormals flush to 0, error 0); 255 with mant 0 gives Inf; 255 with mant≠0 gives NaN; all other values give normal, with E = exp-127.
REQ-014 Stage 2, normal: SHALL form magnitude {1,mant}; if E≥7 it SHALL be shifted left by E-7; if 0≤E<7 it SHALL be shifted right by 7-E; if E<0 the magnitude SHALL be 0 before rounding.
REQ-015 Overflow SHALL be detected as E≥31, with one exception: sign=1, E=31, mant=0 is the exact value -2^31 and SHALL produce 0x80000000 with error 0.
REQ-016 Stage 3 SHALL negate the magnitude when sign=1; an exact zero result SHALL be 0 regardless of sign.
REQ-017 Positive overflow and +Inf SHALL give 0x7FFFFFFF, error 1; negative overflow and -Inf SHALL give 0x80000000, error 1.
REQ-018 NaN SHALL give result 0, error 1.
REQ-019 Every other case SHALL give error 0.
REQ-020 A start arriving in the same cycle as a done SHALL be processed normally, with no stall and no drop.

Reset
REQ-021 While rst is high, result=0, error=0, done=0, and all stage-valid flags SHALL be 0.
REQ-022 A rst asserted mid-operation SHALL discard all in-flight operands; no done SHALL follow for them.
REQ-023 The first start sampled after rst deasserts SHALL complete with the normal 3-cycle latency.

Configuration
REQ-024 Macro BF16_ROUND_EN: when defined, the bits shifted out in REQ-014 (including E<0 cases) SHALL be rounded round-half-to-even.
REQ-025 When BF16_ROUND_EN is undefined, shifted-out bits SHALL be truncated toward zero.
REQ-026 Latency and overflow rules SHALL be identical with and without BF16_ROUND_EN; rounding cannot reach 2^31 because E<7 on that path.

Structure
REQ-027 BF16 field widths (EXP_W=8, MANT_W=7), the bias (127), the Inf/NaN exponent (255), and INPUTOUTBIT SHALL live in shared define.vh; none SHALL be hard-coded locally.
REQ-028 The stage-1 decode SHALL be one natural sub-module, bf16_classify: a combinational decode of a into sign, unbiased exponent, mantissa and a zero/inf/nan/normal class.
REQ-029 The stage registers and the shift/saturate logic SHALL reside in bf16_to_int.

Verification
REQ-030 a=0x3F80 (1.0) with start pulsed once: done 3 cycles later, result=1, error=0; a=0xC2F6 (-123.0) gives result=0xFFFFFF85, error=0.
REQ-031 a=0x3FC0 (1.5) gives 1 truncated and 2 with BF16_ROUND_EN; a=0x4020 (2.5) gives 2 in both builds; a=0x3F00 (0.5) gives 0 in both builds.
REQ-032 a=0x4F00 (+2^31) gives 0x7FFFFFFF, error=1; a=0xCF00 (-2^31) gives 0x80000000, error=0; a=0xCF01 gives 0x80000000, error=1.
REQ-033 a=0x7F80 gives 0x7FFFFFFF, error=1; a=0xFF80 gives 0x80000000, error=1; a=0x7FC0 gives 0, error=1; a=0x8000 and a=0x0001 give 0, error=0.
REQ-034 Starts in 4 consecutive cycles with 0x3F80, 0x4000, 0x4040, 0x4080: done high for 4 consecutive cycles with results 1, 2, 3, 4.
REQ-035 Start, then rst pulsed 2 cycles later: no done appears; a start 1 cycle after rst release produces done 3 cycles later.

Source files
------------

// File: rtl/bf16_to_int_pkg.sv
// Shared types and constants for the BF16 to signed-integer converter.
`include "define.vh"

package bf16_to_int_pkg;

    localparam int EXP_W      = `EXP_W;
    localparam int MANT_W     = `MANT_W;
    localparam int EXP_BIAS   = `EXP_BIAS;
    localparam int EXP_INFNAN = `EXP_INFNAN;

    // Operand class produced by the stage-1 decode
    typedef enum logic [1:0] {
        CLS_ZERO = 2'd0,
        CLS_NORM = 2'd1,
        CLS_INF  = 2'd2,
        CLS_NAN  = 2'd3
    } bf16_cls_e;

endpackage

// File: rtl/bf16_classify.sv
// Combinational BF16 decode: sign, unbiased exponent, mantissa and class.
// Subnormals are treated as zero.
`include "define.vh"

module bf16_classify
    import bf16_to_int_pkg::*;
#(
    parameter int IN_W = `INPUTOUTBIT
) (
    input  logic [IN_W-1:0]          a,
    output logic                     sign,
    output logic signed [EXP_W+1:0]  exp_unb,
    output logic [MANT_W-1:0]        mant,
    output bf16_cls_e                cls
);

    logic [EXP_W-1:0] exp_f;

    // Field split, bias removal and zero/inf/nan/normal classification
    always_comb begin
        sign    = a[IN_W-1];
        exp_f   = a[MANT_W +: EXP_W];
        mant    = a[MANT_W-1:0];
        exp_unb = $signed({2'b00, exp_f}) - $signed((EXP_W+2)'(EXP_BIAS));
        cls     = CLS_NORM;
        if (exp_f == '0) begin
            cls = CLS_ZERO;
        end else if (exp_f == EXP_W'(EXP_INFNAN)) begin
            cls = (mant == '0) ? CLS_INF : CLS_NAN;
        end
    end

endmodule

// File: rtl/define.vh
// Shared BF16 format constants used by the bf16_to_int slice.
`ifndef DEFINE_VH
`define DEFINE_VH

`define INPUTOUTBIT 16
`define EXP_W       8
`define MANT_W      7
`define EXP_BIAS    127
`define EXP_INFNAN  255

`endif

// File: rtl/bf16_to_int.sv
// BF16 to signed two's-complement integer, 3-stage pipeline:
//   p1 unpack/classify, p2 align, p3 sign/saturate (result/error/done).
// Optional macro BF16_ROUND_EN: round-half-to-even on the bits shifted out
// during alignment; without it those bits are truncated toward zero.
`include "define.vh"

module bf16_to_int
    import bf16_to_int_pkg::*;
#(
    parameter int IN_W  = `INPUTOUTBIT,
    parameter int OUT_W = 2*`INPUTOUTBIT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [IN_W-1:0]  a,
    output logic [OUT_W-1:0] result,
    output logic             error,
    output logic             done
);

    localparam logic [OUT_W-1:0] INT_MAX = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic [OUT_W-1:0] INT_MIN = {1'b1, {(OUT_W-1){1'b0}}};

    // Integer part of sig >> s; the extra top bit absorbs a rounding carry
    function automatic logic [MANT_W+1:0] round_shift(input logic [MANT_W:0] sig, input int s);
`ifdef BF16_ROUND_EN
        logic [2*MANT_W+1:0] ext;
        logic [MANT_W+1:0]   ip;
        ext = {sig, {(MANT_W+1){1'b0}}} >> s;
        ip  = {1'b0, ext[2*MANT_W+1 -: MANT_W+1]};
        if (ext[MANT_W] && ((|ext[MANT_W-1:0]) || ip[0])) begin
            ip = ip + (MANT_W+2)'(1);
        end
        return ip;
`else
        return {1'b0, sig >> s};
`endif
    endfunction

    // Magnitude of a normal operand: {1,mant} scaled by 2^(e-MANT_W)
    function automatic logic [OUT_W-1:0] align_mag(input logic [MANT_W-1:0] m, input int e);
        logic [MANT_W:0] sig;
        sig = {1'b1, m};
        if (e >= MANT_W) begin
            return OUT_W'(sig) << (e - MANT_W);
        end
        return OUT_W'(round_shift(sig, MANT_W - e));
    endfunction

    // Out of range unless it is the exactly representable most-negative value
    function automatic logic is_ovf(input logic s, input logic [MANT_W-1:0] m, input int e);
        if (e > OUT_W-1) begin
            return 1'b1;
        end
        return (e == OUT_W-1) && !(s && (m == '0));
    endfunction

    // Apply sign and saturation; returns {error, result}
    function automatic logic [OUT_W:0] sign_sat(input logic s, input logic [OUT_W-1:0] mag,
                                                input logic ovf, input logic nan);
        if (nan) begin
            return {1'b1, {OUT_W{1'b0}}};
        end
        if (ovf) begin
            return {1'b1, (s ? INT_MIN : INT_MAX)};
        end
        return {1'b0, (s ? ((~mag) + OUT_W'(1)) : mag)};
    endfunction

    logic                    cl_sign;
    logic signed [EXP_W+1:0] cl_exp;
    logic [MANT_W-1:0]       cl_mant;
    bf16_cls_e               cl_cls;

    bf16_classify #(.IN_W(IN_W)) u_classify (
        .a       (a),
        .sign    (cl_sign),
        .exp_unb (cl_exp),
        .mant    (cl_mant),
        .cls     (cl_cls)
    );

    logic                    vld_p1_d, vld_p1_q;
    logic                    sign_p1_d, sign_p1_q;
    logic signed [EXP_W+1:0] exp_p1_d, exp_p1_q;
    logic [MANT_W-1:0]       mant_p1_d, mant_p1_q;
    bf16_cls_e               cls_p1_d, cls_p1_q;

    logic                    vld_p2_d, vld_p2_q;
    logic                    sign_p2_d, sign_p2_q;
    logic [OUT_W-1:0]        mag_p2_d, mag_p2_q;
    logic                    ovf_p2_d, ovf_p2_q;
    logic                    nan_p2_d, nan_p2_q;

    logic [OUT_W-1:0]        result_d, result_q;
    logic                    error_d, error_q;
    logic                    done_d, done_q;

    // ---- stage p1: unpack/classify ----
    always_comb begin
        vld_p1_d  = start;
        sign_p1_d = cl_sign;
        exp_p1_d  = cl_exp;
        mant_p1_d = cl_mant;
        cls_p1_d  = cl_cls;
    end

    // ---- stage p2: align and detect overflow ----
    always_comb begin
        vld_p2_d  = vld_p1_q;
        sign_p2_d = sign_p1_q;
        nan_p2_d  = (cls_p1_q == CLS_NAN);
        ovf_p2_d  = (cls_p1_q == CLS_INF);
        mag_p2_d  = '0;
        if (cls_p1_q == CLS_NORM) begin
            mag_p2_d = align_mag(mant_p1_q, int'(exp_p1_q));
            ovf_p2_d = is_ovf(sign_p1_q, mant_p1_q, int'(exp_p1_q));
        end
    end

    // ---- stage p3: sign/saturate, hold output between done pulses ----
    always_comb begin
        done_d   = vld_p2_q;
        result_d = result_q;
        error_d  = error_q;
        if (vld_p2_q) begin
            {error_d, result_d} = sign_sat(sign_p2_q, mag_p2_q, ovf_p2_q, nan_p2_q);
        end
    end

    // Control and output registers; reset drops every in-flight operand
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p1_q <= 1'b0;
            vld_p2_q <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
            error_q  <= 1'b0;
        end else begin
            vld_p1_q <= vld_p1_d;
            vld_p2_q <= vld_p2_d;
            done_q   <= done_d;
            result_q <= result_d;
            error_q  <= error_d;
        end
    end

    // Datapath stage registers, qualified by the valid flags
    always_ff @(posedge clk) begin
        sign_p1_q <= sign_p1_d;
        exp_p1_q  <= exp_p1_d;
        mant_p1_q <= mant_p1_d;
        cls_p1_q  <= cls_p1_d;
        sign_p2_q <= sign_p2_d;
        mag_p2_q  <= mag_p2_d;
        ovf_p2_q  <= ovf_p2_d;
        nan_p2_q  <= nan_p2_d;
    end

    assign result = result_q;
    assign error  = error_q;
    assign done   = done_q;

endmodule

// File: tb/tb_bf16_to_int.sv
// Directed testbench for bf16_to_int (default 16-bit in, 32-bit out).
// Expected values follow BF16_ROUND_EN when it is defined for the build.
module tb_bf16_to_int;

    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] a_in;
    logic [31:0] result;
    logic        error;
    logic        done;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [15:0] a;
        logic [31:0] res;
        logic        err;
    } vec_t;

    vec_t vecs[$];

    bf16_to_int dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .a      (a_in),
        .result (result),
        .error  (error),
        .done   (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %08h, expected %08h", nm, act, req);
        end
    endtask

    // One isolated operand: done must be high only in the third cycle after start
    task automatic run_vec(input int idx, input logic [15:0] av, input logic [31:0] er, input logic ee);
        logic [3:0]  dseq;
        logic [31:0] r_at;
        logic        e_at;
        logic [31:0] r_hold;
        dseq = '0; r_at = '0; e_at = 1'b0; r_hold = '0;
        @(posedge clk); #1;
        start = 1'b1; a_in = av;
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            dseq[3-k] = done;
            if (k == 2) begin r_at = result; e_at = error; end
            if (k == 3) r_hold = result;
            if (k < 3) @(posedge clk);
        end
        check($sformatf("vec%0d a=%04h done_timing", idx, av), {28'd0, dseq}, 32'b0010);
        check($sformatf("vec%0d a=%04h result", idx, av), r_at, er);
        check($sformatf("vec%0d a=%04h error", idx, av), {31'd0, e_at}, {31'd0, ee});
        check($sformatf("vec%0d a=%04h result_held", idx, av), r_hold, er);
    endtask

    initial begin
        logic [15:0] seq_a[8];
        logic [7:0]  dmask;
        logic [31:0] rsv[8];

        rst = 1'b1; start = 1'b0; a_in = '0;

        vecs.push_back('{16'h3F80, 32'h0000_0001, 1'b0});
        vecs.push_back('{16'hC2F6, 32'hFFFF_FF85, 1'b0});
`ifdef BF16_ROUND_EN
        vecs.push_back('{16'h3FC0, 32'h0000_0002, 1'b0});
        vecs.push_back('{16'hBFC0, 32'hFFFF_FFFE, 1'b0});
        vecs.push_back('{16'h3F7F, 32'h0000_0001, 1'b0});
        vecs.push_back('{16'h4060, 32'h0000_0004, 1'b0});
`else
        vecs.push_back('{16'h3FC0, 32'h0000_0001, 1'b0});
        vecs.push_back('{16'hBFC0, 32'hFFFF_FFFF, 1'b0});
        vecs.push_back('{16'h3F7F, 32'h0000_0000, 1'b0});
        vecs.push_back('{16'h4060, 32'h0000_0003, 1'b0});
`endif
        vecs.push_back('{16'h4020, 32'h0000_0002, 1'b0});
        vecs.push_back('{16'h3F00, 32'h0000_0000, 1'b0});
        vecs.push_back('{16'hBF00, 32'h0000_0000, 1'b0});
        vecs.push_back('{16'hC040, 32'hFFFF_FFFD, 1'b0});
        vecs.push_back('{16'h4EFF, 32'h7F80_0000, 1'b0});
        vecs.push_back('{16'h4F00, 32'h7FFF_FFFF, 1'b1});
        vecs.push_back('{16'hCF00, 32'h8000_0000, 1'b0});
        vecs.push_back('{16'hCF01, 32'h8000_0000, 1'b1});
        vecs.push_back('{16'h7F80, 32'h7FFF_FFFF, 1'b1});
        vecs.push_back('{16'hFF80, 32'h8000_0000, 1'b1});
        vecs.push_back('{16'h7FC0, 32'h0000_0000, 1'b1});
        vecs.push_back('{16'hFFC1, 32'h0000_0000, 1'b1});
        vecs.push_back('{16'h8000, 32'h0000_0000, 1'b0});
        vecs.push_back('{16'h0001, 32'h0000_0000, 1'b0});
        vecs.push_back('{16'h0080, 32'h0000_0000, 1'b0});

        // Outputs while held in reset
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_result", result, 32'h0);
        check("reset_error", {31'd0, error}, 32'h0);
        check("reset_done", {31'd0, done}, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;

        foreach (vecs[i]) run_vec(i, vecs[i].a, vecs[i].res, vecs[i].err);

        // Four back-to-back starts; the fourth overlaps the first done
        seq_a[0] = 16'h3F80; seq_a[1] = 16'h4000; seq_a[2] = 16'h4040; seq_a[3] = 16'h4080;
        for (int i = 4; i < 8; i++) seq_a[i] = 16'h0000;
        dmask = '0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            start = (i < 4);
            a_in  = seq_a[i];
            @(negedge clk);
            dmask[i] = done;
            rsv[i]   = result;
        end
        check("b2b_done_mask", {24'd0, dmask}, 32'h0000_0078);
        for (int i = 0; i < 4; i++)
            check($sformatf("b2b_result%0d", i), rsv[i+3], 32'(i + 1));

        // Reset two cycles after a start, then a start one cycle after release
        dmask = '0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            start = (i == 0) || (i == 4);
            a_in  = (i == 0) ? 16'h4000 : 16'h4040;
            rst   = (i == 2);
            @(negedge clk);
            dmask[i % 8] = (i < 8) ? done : dmask[i % 8];
            rsv[i % 8]   = (i < 8) ? result : rsv[i % 8];
            if (i == 2) begin
                check("midrst_result", result, 32'h0);
                check("midrst_error", {31'd0, error}, 32'h0);
                check("midrst_done", {31'd0, done}, 32'h0);
            end
        end
        check("postrst_done_mask", {24'd0, dmask}, 32'h0000_0080);
        check("postrst_result", rsv[7], 32'h0000_0003);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
